// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the round-robin memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DEPTH          = 256;
  localparam int DEF_CLEAR_ON_RESET = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, first set request wins; ptr moves past the winner on advance.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_i,
  input  logic                       adv_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [$clog2(N_REQ)-1:0]   gnt_idx_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (found) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) ptr_d = IDX_W'((int'(gnt_idx_o) + 1) % N_REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_ctrl_rr.sv
// N_REQ-port single-port memory controller: registered round-robin grant, 3-cycle transaction, optional post-reset clear.
module mem_ctrl_rr
  import mem_ctrl_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           rw,
  input  logic [N_REQ*ADDR_W-1:0]    addr,
  input  logic [N_REQ*DATA_W-1:0]    wdata,
  output logic [N_REQ-1:0]           ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       err,
  output logic                       busy
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam int               AW1       = ADDR_W + 1;
  localparam state_t           RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [ADDR_W:0]  DEPTH_L   = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  g_q, g_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q;

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              adv;
  logic              in_range;
  logic              rd_en, rd_zero;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .adv_i     (adv),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    clr_cnt_d = clr_cnt_q;
    err_d     = err_q;
    ack_d     = '0;
    adv       = 1'b0;
    rd_en     = 1'b0;
    rd_zero   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        if (|req) begin
          adv     = 1'b1;
          g_d     = gnt;
          rw_d    = rw[gnt_idx];
          addr_d  = addr_arr[gnt_idx];
          wdata_d = wdata_arr[gnt_idx];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Out-of-range requests never touch the array; they return zero data with err.
        mem_we  = in_range && !rw_q;
        rd_en   = in_range && rw_q;
        rd_zero = !in_range;
        err_d   = !in_range;
        ack_d   = g_q;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RST_STATE;
      g_q       <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      clr_cnt_q <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      clr_cnt_q <= clr_cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      if (rd_en)        rdata_q <= mem[addr_q];
      else if (rd_zero) rdata_q <= '0;
    end
  end

  // Array has no reset: only the CLEAR walk or a granted write changes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule
